cp0_exc_unit: RTL
=================

Name: cp0_exc_unit

Overview:
- Coprocessor-0 block in the MEM stage. It consumes the c0 write, mfc0 select and eret controls registered by the EX/MEM control register.
- Holds SR, Cause, EPC and PRId.
- Samples hardware interrupts, decides exception/interrupt entry for the instruction currently in MEM, and supplies the redirect PC and flush request to the fetch/hazard logic.

Parameters:
- PRID, 32'h0000_2017, constant value returned by PRId (reg 15).
- EXC_VECTOR, 32'h0000_4180, handler entry address.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- m_valid  in  1  MEM holds a real instruction, not a bubble from EXMEM_clr or reset.
- pc_m  in  32  PC of the MEM instruction.
- bd_m  in  1  MEM instruction is in a branch delay slot.
- exc_valid_m  in  1  MEM instruction raised a synchronous exception.
- exc_code_m  in  5  ExcCode of that exception.
- hw_int  in  6  external interrupt lines, level-sensitive.
- c0wr_m  in  1  mtc0 in MEM.
- mfc0sel_m  in  1  mfc0 in MEM; qualifies the read port only.
- eret_m  in  1  eret in MEM (nPC_sel_eret).
- c0_addr  in  5  CP0 register number (rd field).
- c0_din  in  32  mtc0 write data.
- c0_dout  out  32  mfc0 read data.
- exc_take  out  1  exception/interrupt is taken this cycle.
- eret_take  out  1  eret is taken this cycle.
- redirect_pc  out  32  EXC_VECTOR when exc_take; EPC when eret_take; otherwise 0.
- flush_all  out  1  equals exc_take | eret_take; clears IF/ID, ID/EX and EX/MEM, and kills the MEM store.
- epc_out  out  32  current EPC.

Behaviour:
- Reset (reset=0, asynchronous): SR=0 (IM=0, EXL=0, IE=0), Cause=0, EPC=0. Every output is 0 while reset is held.
- SR fields: IM[15:10], EXL[1], IE[0]. All other bits read 0 and ignore writes.
- Cause fields: BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
- Cause.IP is loaded from hw_int on every posedge (1-cycle sample), including while EXL=1.
- int_req = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL. It uses the registered IP, so interrupt latency is 1 cycle after the line rises.
- exc_take = m_valid & ~SR.EXL & (int_req | exc_valid_m). This output is combinational. When m_valid=0 (bubble), entry is deferred and int_req stays pending.
- On the posedge where exc_take=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_req ? 0 : exc_code_m. An interrupt has priority over a simultaneous synchronous exception.
  - Cause.BD <= bd_m.
  - EPC <= bd_m ? {pc_m[31:2],2'b00}-4 : {pc_m[31:2],2'b00}. The subtraction is 32-bit and wraps, so pc_m=0 with bd_m=1 gives EPC=32'hFFFF_FFFC.
- eret_take = m_valid & eret_m & ~exc_take. On that posedge, SR.EXL <= 0.
- mtc0 takes effect at the posedge when m_valid & c0wr_m & ~exc_take:
  - addr 12 writes SR fields only.
  - addr 14 writes EPC with bits [1:0] forced to 0.
  - addr 13 and addr 15 are read-only; writes are ignored.
- Simultaneous events:
  - Exception beats mtc0 and eret in the same cycle; both are dropped.
  - An mtc0 to EPC never coincides with eret in valid code. If it does, the eret uses the old EPC and the EPC write still commits.
- Read port is combinational from registered state:
  - addr 12 gives SR, 13 gives Cause, 14 gives EPC, 15 gives PRID.
  - Any other address reads 0.
  - A write in the same cycle is not forwarded; the new value is visible the next cycle.
- While EXL=1, no nested entry occurs even if exc_valid_m=1; the hazard unit guarantees this never arises in practice.
- Reset asserted mid-handler clears EXL immediately and asynchronously. A pending int_req then waits for software to set IE/IM again.
- The block stalls nothing; a stall upstream simply presents m_valid=0.

Test Plan:
1. Reset, then release; mfc0 to addrs 12/13/14/15 -> 0, 0, 0, 32'h0000_2017; addr 7 -> 0.
2. mtc0 SR=32'h0000_FC01 then mtc0 EPC=32'h0000_3007 -> SR reads 32'h0000_FC01, EPC reads 32'h0000_3004; mtc0 Cause=32'hFFFF_FFFF leaves Cause at 0.
3. SR=32'h0000_0401, raise hw_int[0] at cycle t, pc_m=32'h0000_3010, m_valid=1 -> exc_take=1 at t+1; after the edge EXL=1, ExcCode=0, EPC=32'h0000_3010, redirect_pc=32'h0000_4180, flush_all=1 for exactly 1 cycle.
4. exc_valid_m=1, exc_code_m=5'd10, bd_m=1, pc_m=32'h0000_3020, no interrupt -> EPC=32'h0000_301C, Cause=32'h8000_0028; with hw_int[0] enabled in the same cycle -> ExcCode=0 instead.
5. eret_m=1 with EXL=1 and EPC=32'h0000_3010 -> eret_take=1, redirect_pc=32'h0000_3010; EXL=0 next cycle. Pending enabled interrupt plus m_valid=0 -> no entry until m_valid=1.
6. Same cycle c0wr_m=1 (SR, din=0) and exc_valid_m=1 -> exception taken, SR write dropped (IE stays 1). Assert reset mid-handler -> EXL=0 and outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: MEM-stage coprocessor 0 holding SR/Cause/EPC/PRId.
// Decides exception/interrupt entry and eret, and drives the fetch redirect and the pipeline flush.
module cp0_exc_unit #(
    parameter logic [31:0] PRID       = 32'h0000_2017,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        exc_valid_m,
    input  logic [4:0]  exc_code_m,
    input  logic [5:0]  hw_int,
    input  logic        c0wr_m,
    input  logic        mfc0sel_m,
    input  logic        eret_m,
    input  logic [4:0]  c0_addr,
    input  logic [31:0] c0_din,
    output logic [31:0] c0_dout,
    output logic        exc_take,
    output logic        eret_take,
    output logic [31:0] redirect_pc,
    output logic        flush_all,
    output logic [31:0] epc_out
);
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic [31:0] sr;
    logic [31:0] cause;
    logic [31:0] pc_al;
    logic [31:0] epc_next;
    logic        int_req;
    logic        exc_raw;
    logic        eret_raw;
    logic        wr;
    logic [31:0] rd_val;

    assign sr       = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
    assign cause    = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
    assign int_req  = |(cause_ip & sr_im) & sr_ie & ~sr_exl;
    assign exc_raw  = m_valid & ~sr_exl & (int_req | exc_valid_m);
    assign eret_raw = m_valid & eret_m & ~exc_raw;
    assign wr       = m_valid & c0wr_m & ~exc_raw;
    assign pc_al    = pc_m & ~32'd3;
    assign epc_next = bd_m ? pc_al - 32'd4 : pc_al;

    // Outputs are forced low while reset is held, even if the inputs would request entry.
    assign exc_take    = reset & exc_raw;
    assign eret_take   = reset & eret_raw;
    assign flush_all   = exc_take | eret_take;
    assign redirect_pc = exc_take ? EXC_VECTOR : eret_take ? epc : 32'd0;
    assign epc_out     = reset ? epc : 32'd0;

    always_comb begin
        rd_val = c0_addr == 5'd12 ? sr :
                 c0_addr == 5'd13 ? cause :
                 c0_addr == 5'd14 ? epc :
                 c0_addr == 5'd15 ? PRID : 32'd0;
        c0_dout = (reset & mfc0sel_m) ? rd_val : 32'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hw_int;
            if (exc_raw) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? 5'd0 : exc_code_m;
                cause_bd  <= bd_m;
                epc       <= epc_next;
            end else begin
                if (eret_raw)
                    sr_exl <= 1'b0;
                if (wr && c0_addr == 5'd12) begin
                    sr_im  <= c0_din[15:10];
                    sr_exl <= c0_din[1];
                    sr_ie  <= c0_din[0];
                end
                if (wr && c0_addr == 5'd14)
                    epc <= {c0_din[31:2], 2'b00};
            end
        end
    end
endmodule
